vga_scanout: RTL and testbench

- Downstream consumer of the framebuffer written by `gpu` (6-bit RRGGBB pixels at `addr = 640*row + col`).
- Generates 640x480@60 VGA timing on a pixel-enable tick.
- Fetches each pixel from a synchronous framebuffer read port and drives registered sync and 2-bit-per-channel colour outputs.
- Raises `vblank` / `frame_start` so the command side can pace `start` pulses to the GPU.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_timing.sv | 48 ++++
 rtl/vga_scanout.sv | 111 +++++++++++
 tb/tb_vga_scanout.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, FSM states and pixel field positions.
// FB_DOUBLE_EN widens the default framebuffer address to hold two frames.
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START     = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END       = HS_START + H_SYNC_DEF;
  localparam int VS_START     = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END       = VS_START + V_SYNC_DEF;
  localparam int CNT_W        = 10;
  localparam int PIX_W_DEF    = 6;
  localparam int R_LSB        = 4;
  localparam int G_LSB        = 2;
  localparam int B_LSB        = 0;
`ifdef FB_DOUBLE_EN
  localparam int ADDR_W_DEF   = 20;
`else
  localparam int ADDR_W_DEF   = 19;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: h/v pixel counters advancing on adv, with raw sync, active and frame-wrap strobes.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic             active,
  output logic             vblank_raw,
  output logic             v_wrap
);
  localparam logic [CNT_W-1:0] HA     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VA     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS0    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS1    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS0    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS1    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  logic h_wrap;
  assign h_wrap     = h_cnt == H_LAST;
  assign v_wrap     = h_wrap && v_cnt == V_LAST;
  assign active     = h_cnt < HA && v_cnt < VA;
  assign vblank_raw = v_cnt >= VA;
  assign hs_raw     = !(h_cnt >= HS0 && h_cnt < HS1);
  assign vs_raw     = !(v_cnt >= VS0 && v_cnt < VS1);
  always_ff @(posedge clk)
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (adv) begin
      h_cnt <= h_wrap ? '0 : h_cnt + CNT_W'(1);
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
    end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA scanout FSM, incremental framebuffer addressing, 1-tick read pipeline and sync/colour registers.
// Define FB_DOUBLE_EN for double buffering (swap_req/front_sel, second frame at offset H_ACTIVE*V_ACTIVE).
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PIX_W    = PIX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              enable,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              hsync,
  output logic              vsync,
  output logic [1:0]        red,
  output logic [1:0]        green,
  output logic [1:0]        blue,
  output logic              vblank,
  output logic              frame_start,
  output logic              busy
`ifdef FB_DOUBLE_EN
  ,
  input  logic              swap_req,
  output logic              front_sel
`endif
);
  state_t state, state_nx;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic hs_raw, vs_raw, active, vblank_raw, v_wrap, issue;
  logic hs_d, vs_d, vb_d, act_d, rd_valid;
  logic [PIX_W-1:0] pix_q, pix;
  logic [ADDR_W-1:0] ofs;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .reset(reset), .adv(issue), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hs_raw(hs_raw), .vs_raw(vs_raw), .active(active), .vblank_raw(vblank_raw), .v_wrap(v_wrap)
  );

  // A tick issues a pixel whenever scanning, including the IDLE tick that starts it.
  assign issue       = pix_en && !reset && (state != IDLE || enable);
  assign rd_en       = issue && active;
  assign frame_start = issue && h_cnt == '0 && v_cnt == '0;
  assign busy        = state != IDLE;

  always_comb state_nx = !pix_en ? state : enable ? RUN : (state == IDLE || v_wrap) ? IDLE : DRAIN;

  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge clk)
    if (reset) ofs <= '0;
    else if (issue) ofs <= v_wrap ? '0 : active ? ofs + ADDR_W'(1) : ofs;

`ifdef FB_DOUBLE_EN
  logic swap_pend, sel_now;
  // The swap takes effect on the frame_start read itself so the whole new frame uses the new buffer.
  assign sel_now = front_sel ^ (frame_start & swap_pend);
  assign rd_addr = sel_now ? ofs + ADDR_W'(H_ACTIVE * V_ACTIVE) : ofs;
  always_ff @(posedge clk)
    if (reset) begin
      front_sel <= 1'b0;
      swap_pend <= 1'b0;
    end else begin
      front_sel <= sel_now;
      swap_pend <= (swap_pend & !frame_start) | swap_req;
    end
`else
  assign rd_addr = ofs;
`endif

  // Bypass rd_data when the read landed this clk (pix_en every clk), else use the captured word.
  assign pix = rd_valid ? rd_data : pix_q;

  always_ff @(posedge clk)
    if (reset) begin
      rd_valid <= 1'b0;
      pix_q    <= '0;
      {hs_d, vs_d, vb_d, act_d} <= 4'b1100;
      {hsync, vsync, vblank}    <= 3'b110;
      {red, green, blue}        <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_valid) pix_q <= rd_data;
      if (pix_en && !issue) begin
        {hs_d, vs_d, vb_d, act_d} <= 4'b1100;
        {hsync, vsync, vblank}    <= 3'b110;
        {red, green, blue}        <= '0;
      end else if (pix_en) begin
        {hs_d, vs_d, vb_d, act_d} <= {hs_raw, vs_raw, vblank_raw, active};
        {hsync, vsync, vblank}    <= {hs_d, vs_d, vb_d};
        red   <= act_d ? pix[R_LSB+:2] : 2'b0;
        green <= act_d ? pix[G_LSB+:2] : 2'b0;
        blue  <= act_d ? pix[B_LSB+:2] : 2'b0;
      end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed bench on a shrunken 16x11 raster; every tick checks reads, syncs and colour.
module tb_vga_scanout;
  import vga_pkg::*;
  localparam int HA = 8, HF = 2, HSW = 3, HB = 3, HT = HA + HF + HSW + HB;
  localparam int VA = 6, VF = 1, VSW = 2, VB = 2, VT = VA + VF + VSW + VB;
  localparam int FB = HA * VA;
  localparam int AW = ADDR_W_DEF;

  logic clk_tb = 1'b0, reset = 1'b1, pix_en = 1'b0, enable = 1'b0;
  logic [AW-1:0] rd_addr;
  logic rd_en, hsync, vsync, vblank, frame_start, busy;
  logic [5:0] rd_data = 6'h0;
  logic [1:0] red, green, blue;
  logic [5:0] mem [0:2*FB-1];
  bit b_sel = 0, b_pend = 0;
`ifdef FB_DOUBLE_EN
  logic swap_req = 1'b0, front_sel;
`endif

  int n_chk = 0, n_pass = 0;
  int b_state = 0, hc = 0, vc = 0, ph = 0, pv = 0, pa = 0, white_hits = 0;
  bit b_prev = 0, half = 1;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut (
    .clk(clk_tb), .reset(reset), .pix_en(pix_en), .enable(enable),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .vblank(vblank), .frame_start(frame_start), .busy(busy)
`ifdef FB_DOUBLE_EN
    , .swap_req(swap_req), .front_sel(front_sel)
`endif
  );

  always #5 clk_tb = ~clk_tb;
  always @(posedge clk_tb) if (rd_en) rd_data <= mem[int'(rd_addr)];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit act(input int h, input int v);
    return h < HA && v < VA;
  endfunction

  task automatic fill_pattern();
    for (int i = 0; i < 2 * FB; i++) mem[i] = 6'(i);
  endtask

  task automatic tick();
    bit run, fs, sel_now, wrap;
    int ofs;
    run = b_state != 0 || enable;
    fs = run && hc == 0 && vc == 0;
    wrap = run && hc == HT - 1 && vc == VT - 1;
    sel_now = b_sel ^ (fs & b_pend);
    ofs = !run ? 0 : vc >= VA ? FB : hc < HA ? vc * HA + hc : (vc + 1) * HA;
    ofs += sel_now ? FB : 0;
    pix_en = 1'b1;
    #1;
    chk("rd_en", rd_en, run && act(hc, vc));
    chk("frame_start", frame_start, fs);
    chk("rd_addr", rd_addr, ofs);
    @(posedge clk_tb);
    #1;
    pix_en = 1'b0;
    if (run && b_prev) begin
      chk("hsync", hsync, !(ph >= HA + HF && ph < HA + HF + HSW));
      chk("vsync", vsync, !(pv >= VA + VF && pv < VA + VF + VSW));
      chk("vblank", vblank, pv >= VA);
      chk("rgb", {red, green, blue}, act(ph, pv) ? mem[pa] : 6'h0);
    end else
      chk("idle_out", {hsync, vsync, vblank, red, green, blue}, 9'b110_000000);
    if ({red, green, blue} == 6'h3f) white_hits++;
    b_state = enable ? 1 : (b_state == 0 || wrap) ? 0 : 2;
    chk("busy", busy, b_state != 0);
    if (fs) begin
      b_sel = sel_now;
      b_pend = 0;
    end
`ifdef FB_DOUBLE_EN
    chk("front_sel", front_sel, b_sel);
`endif
    b_prev = run;
    ph = hc;
    pv = vc;
    pa = ofs;
    if (run) begin
      hc = (hc + 1) % HT;
      if (hc == 0) vc = (vc + 1) % VT;
    end
    if (half) begin
      @(posedge clk_tb);
      #1;
    end
  endtask

  task automatic run_to(input int h, input int v);
    for (int g = 0; g < HT * VT + 2 && !(hc == h && vc == v); g++) tick();
  endtask

  initial begin
    fill_pattern();
    repeat (3) @(posedge clk_tb);
    #1;
    chk("reset_out", {hsync, vsync, red, green, blue, vblank, busy, rd_en, frame_start}, 12'b11_000000_0000);
    reset = 1'b0;
    chk("reset_addr", rd_addr, 0);
    enable = 1'b1;
    repeat (HT * VT + 1) tick();
    half = 0;
    repeat (HT * VT) tick();
    half = 1;
    for (int i = 0; i < 2 * FB; i++) mem[i] = 6'h0;
    mem[2 * HA + 5] = 6'h3f;
    white_hits = 0;
    repeat (HT * VT) tick();
    chk("white_hits", white_hits, 1);
    fill_pattern();
    run_to(3, 2);
    repeat (7) @(posedge clk_tb);
    #1;
    run_to(0, 3);
    enable = 1'b0;
    for (int g = 0; g < HT * VT + 2 && b_state != 0; g++) tick();
    repeat (4) tick();
    enable = 1'b1;
    run_to(4, 3);
    reset = 1'b1;
    @(posedge clk_tb);
    #1;
    reset = 1'b0;
    chk("mid_reset", {hsync, vsync, red, green, blue, rd_en, busy}, 10'b11_000000_00);
    chk("mid_reset_addr", rd_addr, 0);
    b_state = 0; hc = 0; vc = 0; b_prev = 0; b_sel = 0; b_pend = 0;
    repeat (2 * HT) tick();
`ifdef FB_DOUBLE_EN
    run_to(0, 4);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    b_pend = 1;
    repeat (HT * VT + 2 * HT) tick();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
